// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch controller
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        DONE     = 2'd3
    } fetch_state_t;

    localparam int ADDR_W_DEF      = 16;
    localparam int TIMEOUT_CYC_DEF = 15;

    localparam logic LH_LOW  = 1'b0;
    localparam logic LH_HIGH = 1'b1;

endpackage

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - consecutive wait-cycle counter that flags a memory timeout
module fetch_timer #(
    parameter int CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(CYC + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (run) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the CYC-th consecutive idle cycle, not the one after it
    assign expired = run && (count == CW'(CYC - 1));

endmodule

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - two-byte instruction fetch FSM (optional timeout: FETCH_TIMEOUT_EN)
module instruction_fetch_controller
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] PC,
    input  logic              Flush,
    output logic              MemRead,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemReady,
    output logic              IRWrite,
    output logic              IRLH,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] NextPC,
    output logic              FetchErr
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc_q;
    logic              in_fetch;
    logic              timeout;

    assign in_fetch = (state == FETCH_LO) || (state == FETCH_HI);

`ifdef FETCH_TIMEOUT_EN
    logic wait_clr;
    logic wait_run;

    // Clearing whenever outside a fetch state guarantees a fresh count on entry
    assign wait_clr = !in_fetch || MemReady || Flush;
    assign wait_run = in_fetch && !MemReady && !Flush;

    fetch_timer #(
        .CYC (TIMEOUT_CYC)
    ) u_fetch_timer (
        .clk     (Clock),
        .rst     (Reset),
        .clr     (wait_clr),
        .run     (wait_run),
        .expired (timeout)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q <= '0;
        end else if ((state == IDLE) && Start && !Flush) begin
            pc_q <= PC;
        end
    end

    always_comb begin
        state_next = state;
        if (Flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) state_next = FETCH_LO;
                end
                FETCH_LO: begin
                    if (MemReady)     state_next = FETCH_HI;
                    else if (timeout) state_next = IDLE;
                end
                FETCH_HI: begin
                    if (MemReady)     state_next = DONE;
                    else if (timeout) state_next = IDLE;
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Reset masks every strobe combinationally so a mid-fetch reset issues no write
    always_comb begin
        MemRead  = 1'b0;
        MemAddr  = '0;
        IRLH     = LH_LOW;
        Done     = 1'b0;
        NextPC   = '0;
        FetchErr = 1'b0;
        Busy     = (state != IDLE);
        if (!Reset) begin
            case (state)
                FETCH_LO: begin
                    MemRead = 1'b1;
                    MemAddr = pc_q;
                    IRLH    = LH_LOW;
                end
                FETCH_HI: begin
                    MemRead = 1'b1;
                    MemAddr = pc_q + ADDR_W'(1);
                    IRLH    = LH_HIGH;
                end
                DONE: begin
                    Done   = !Flush;
                    NextPC = pc_q + ADDR_W'(2);
                end
                default: begin
                end
            endcase
            FetchErr = in_fetch && timeout && !MemReady && !Flush;
        end
        IRWrite = MemRead && MemReady && !Flush && !Reset;
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - directed self-checking bench for instruction_fetch_controller
module tb_instruction_fetch_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] pc;
    logic        flush;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic        ir_write;
    logic        irlh;
    logic        busy;
    logic        done;
    logic [15:0] next_pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;
    int err_pulses;
    int err_cycle;

    instruction_fetch_controller #(
        .ADDR_W      (16),
        .TIMEOUT_CYC (15)
    ) dut (
        .Clock    (clk),
        .Reset    (rst),
        .Start    (start),
        .PC       (pc),
        .Flush    (flush),
        .MemRead  (mem_read),
        .MemAddr  (mem_addr),
        .MemReady (mem_ready),
        .IRWrite  (ir_write),
        .IRLH     (irlh),
        .Busy     (busy),
        .Done     (done),
        .NextPC   (next_pc),
        .FetchErr (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 2 ns after it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pc = 16'h0000; flush = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_memread", mem_read, 0);
        check("reset_next_pc", next_pc, 0);
        rst = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_irwrite", ir_write, 0);
        check("idle_fetcherr", fetch_err, 0);

        // Basic fetch at 0x0100 with memory always ready
        start = 1'b1; pc = 16'h0100; mem_ready = 1'b1;
        #1;
        check("start_cycle_irwrite", ir_write, 0);
        tick();
        start = 1'b0; pc = 16'h0000;
        #1;
        check("lo_memread", mem_read, 1);
        check("lo_addr", mem_addr, 16'h0100);
        check("lo_irlh", irlh, 0);
        check("lo_irwrite", ir_write, 1);
        check("lo_busy", busy, 1);
        tick();
        check("hi_addr", mem_addr, 16'h0101);
        check("hi_irlh", irlh, 1);
        check("hi_irwrite", ir_write, 1);
        tick();
        check("done_pulse", done, 1);
        check("done_next_pc", next_pc, 16'h0102);
        check("done_irwrite", ir_write, 0);
        check("done_memread", mem_read, 0);
        check("done_addr", mem_addr, 0);
        check("done_irlh", irlh, 0);
        tick();
        check("after_done_busy", busy, 0);
        check("after_done_done", done, 0);

        // Address wrap at the top of memory
        start = 1'b1; pc = 16'hFFFF;
        tick();
        start = 1'b0;
        #1;
        check("wrap_lo_addr", mem_addr, 16'hFFFF);
        tick();
        check("wrap_hi_addr", mem_addr, 16'h0000);
        tick();
        check("wrap_done", done, 1);
        check("wrap_next_pc", next_pc, 16'h0001);
        tick();

        // Two wait cycles in FETCH_HI plus an ignored Start while busy
        start = 1'b1; pc = 16'h1234;
        tick();
        start = 1'b0;
        tick();
        mem_ready = 1'b0; start = 1'b1; pc = 16'h4000;
        #1;
        check("wait1_addr", mem_addr, 16'h1235);
        check("wait1_irwrite", ir_write, 0);
        tick();
        start = 1'b0;
        #1;
        check("wait2_addr", mem_addr, 16'h1235);
        check("wait2_irwrite", ir_write, 0);
        check("wait2_irlh", irlh, 1);
        tick();
        mem_ready = 1'b1;
        #1;
        check("wait_end_irwrite", ir_write, 1);
        tick();
        check("wait_done", done, 1);
        check("wait_next_pc", next_pc, 16'h1236);
        tick();
        check("ignored_start_busy", busy, 0);

        // Flush in FETCH_HI with memory ready
        start = 1'b1; pc = 16'h0200;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        check("flush_irwrite", ir_write, 0);
        check("flush_done", done, 0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_idle_busy", busy, 0);
        check("flush_idle_memread", mem_read, 0);
        tick();
        check("flush_no_done", done, 0);

        // Start and Flush together in IDLE
        start = 1'b1; flush = 1'b1; pc = 16'h0300;
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        check("start_flush_busy", busy, 0);

        // Memory never answers
        start = 1'b1; pc = 16'h0400; mem_ready = 1'b0;
        tick();
        start = 1'b0;
        err_pulses = 0;
        err_cycle  = 0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (fetch_err === 1'b1) begin
                err_pulses++;
                err_cycle = i;
            end
            tick();
        end
`ifdef FETCH_TIMEOUT_EN
        check("timeout_pulses", err_pulses, 1);
        check("timeout_cycle", err_cycle, 15);
        check("timeout_busy", busy, 0);
`else
        check("no_timeout_pulses", err_pulses, 0);
        check("no_timeout_busy", busy, 1);
        check("no_timeout_addr", mem_addr, 16'h0400);
`endif

        // Reset in FETCH_LO (Start is ignored if already fetching)
        start = 1'b1; pc = 16'h0400;
        tick();
        start = 1'b0;
        #1;
        check("pre_reset_lo_addr", mem_addr, 16'h0400);
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        check("reset_cycle_irwrite", ir_write, 0);
        tick();
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        check("post_reset_busy", busy, 0);
        check("post_reset_memread", mem_read, 0);
        check("post_reset_addr", mem_addr, 0);
        check("post_reset_irlh", irlh, 0);
        check("post_reset_done", done, 0);
        check("post_reset_fetcherr", fetch_err, 0);

        // Clean fetch after reset
        start = 1'b1; pc = 16'h0500; mem_ready = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("clean_lo_addr", mem_addr, 16'h0500);
        tick();
        check("clean_hi_addr", mem_addr, 16'h0501);
        tick();
        check("clean_done", done, 1);
        check("clean_next_pc", next_pc, 16'h0502);
        tick();
        check("clean_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 Parameter ADDR_W, default 16: width of the program-counter and memory address.
REQ-002 Parameter TIMEOUT_CYC, default 15: maximum wait cycles per byte read (used only with REQ-031).
REQ-003 Port Clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1: synchronous, active-high reset.
REQ-005 Port Start, input, 1: request to fetch one 16-bit instruction.
REQ-006 Port PC, input, ADDR_W: address of the instruction's low byte; sampled on accepted Start.
REQ-007 Port Flush, input, 1: abort any fetch in progress.
REQ-008 Port MemRead, output, 1: byte read request to memory.
REQ-009 Port MemAddr, output, ADDR_W: byte address for MemRead.
REQ-010 Port MemReady, input, 1: memory data valid on the 8-bit byte bus this cycle.
REQ-011 Port IRWrite, output, 1: write strobe to the instruction register.
REQ-012 Port IRLH, output, 1: byte select to the instruction register (0 = low byte [7:0], 1 = high byte [15:8]).
REQ-013 Port Busy, output, 1: high whenever the state is not IDLE.
REQ-014 Port Done, output, 1: one-cycle pulse when both bytes are loaded.
REQ-015 Port NextPC, output, ADDR_W: latched PC + 2 (modulo 2^ADDR_W); valid while Done is high.
REQ-016 Port FetchErr, output, 1: one-cycle pulse on a memory timeout.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH_LO, FETCH_HI and DONE.
REQ-018 In IDLE, Start=1 with Flush=0 SHALL latch PC into pc_q and move to FETCH_LO.
REQ-019 Start SHALL be ignored in every state other than IDLE.
REQ-020 FETCH_LO: MemRead=1, MemAddr=pc_q, IRLH=0; on MemReady=1, IRWrite=1 in the same cycle, then FETCH_HI.
REQ-021 FETCH_HI: MemRead=1, MemAddr=pc_q+1 (wraps modulo 2^ADDR_W), IRLH=1; on MemReady=1, IRWrite=1 in the same cycle, then DONE.
REQ-022 IRWrite SHALL equal MemRead AND MemReady AND NOT Flush; it is never asserted in IDLE or DONE.
REQ-023 DONE: Done=1 for exactly one cycle, NextPC=pc_q+2, then IDLE.
REQ-024 MemReady outside FETCH_LO and FETCH_HI SHALL be ignored.
REQ-025 With MemReady held high, Done SHALL assert 3 cycles after the Start cycle; each low MemReady cycle adds 1 cycle.
REQ-026 Flush=1 in any state SHALL force IDLE on the next edge and suppress IRWrite and Done in that cycle.
REQ-027 Flush and Start both high in IDLE: Flush wins and no fetch starts.
REQ-028 IRLH SHALL be 0 in IDLE and DONE; MemAddr SHALL be 0 when MemRead=0.

Reset
REQ-029 Reset=1 SHALL put the FSM in IDLE, clear pc_q and the timeout counter, and drive MemRead, IRWrite, IRLH, Busy, Done and FetchErr to 0 and NextPC to 0.
REQ-030 Reset SHALL take priority over Flush and Start, including in the middle of a fetch; no IRWrite is issued in the reset cycle.

Configuration
REQ-031 With macro FETCH_TIMEOUT_EN defined, a wait counter SHALL clear on entry to FETCH_LO and FETCH_HI and on MemReady. After TIMEOUT_CYC consecutive cycles without MemReady, the FSM SHALL return to IDLE and FetchErr SHALL pulse for one cycle.
REQ-032 With FETCH_TIMEOUT_EN undefined, the FSM SHALL wait indefinitely, FetchErr SHALL be tied to 0, and the port list SHALL be unchanged.

Structure
REQ-033 Shared package fetch_pkg SHALL hold the state enum, the ADDR_W default, the TIMEOUT_CYC default and the IRLH encodings (LH_LOW=0, LH_HIGH=1).
REQ-034 The wait counter SHALL be a sub-module fetch_timer, instantiated only under FETCH_TIMEOUT_EN; everything else is flat.

Verification
REQ-035 Reset, then Start with PC=0x0100 and MemReady=1 constantly -> MemAddr 0x0100 (IRLH=0, IRWrite) then 0x0101 (IRLH=1, IRWrite); Done on cycle 3 with NextPC=0x0102.
REQ-036 PC=0xFFFF -> high-byte MemAddr=0x0000; NextPC=0x0001.
REQ-037 MemReady low for 2 cycles in FETCH_HI -> MemAddr held and IRWrite=0 during the wait; Done on cycle 5; a Start pulse while Busy is ignored.
REQ-038 Flush in FETCH_HI with MemReady=1 -> no IRWrite, no Done, IDLE next cycle; Start and Flush together in IDLE -> Busy stays 0.
REQ-039 FETCH_TIMEOUT_EN defined, TIMEOUT_CYC=15, MemReady=0 forever -> FetchErr pulses once after 15 wait cycles in FETCH_LO, then IDLE; macro undefined -> Busy stays 1, FetchErr=0.
REQ-040 Reset asserted in FETCH_LO -> all outputs 0 the next cycle; a subsequent Start runs a clean fetch.
